// File: rtl/mult_div_unit.sv
// Sequential radix-2 signed multiply (Booth) / divide (restoring) unit for the control FSM.
// Optional MULTDIV_BUSY_EN adds a registered busy output.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MultCtrl,
  input  logic             DivCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res,
  output logic             MultOut,
  output logic             DivOut,
  output logic             divZero
`ifdef MULTDIV_BUSY_EN
  ,
  output logic             busy
`endif
);

  localparam int unsigned MW = 2 * WIDTH + 2;

  typedef enum logic [2:0] {
    IDLE,
    MULT_RUN,
    DIV_RUN,
    DIV_FIX,
    DONE,
    RELEASE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH:0]   mcand;
  logic [MW-1:0]    mreg;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH:0]   booth_hi;
  logic [MW-1:0]    mult_step;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  // Booth step: upper part is one bit wider so +/-(-2**(W-1)) cannot overflow
  always_comb begin
    booth_hi = mreg[MW-1:WIDTH+1];
    case (mreg[1:0])
      2'b01:   booth_hi = booth_hi + mcand;
      2'b10:   booth_hi = booth_hi - mcand;
      default: booth_hi = mreg[MW-1:WIDTH+1];
    endcase
    mult_step = {booth_hi[WIDTH], booth_hi, mreg[WIDTH:1]};
  end

  // Restoring divide step on unsigned magnitudes
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, dvs};
    if (diff[WIDTH+1]) begin
      rem_step = shifted[WIDTH-1:0];
      quo_step = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_step = diff[WIDTH-1:0];
      quo_step = {quo[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    abs_a = A[WIDTH-1] ? WIDTH'(0) - A : A;
    abs_b = B[WIDTH-1] ? WIDTH'(0) - B : B;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      mcand   <= '0;
      mreg    <= '0;
      dvs     <= '0;
      rem     <= '0;
      quo     <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      hi_res  <= '0;
      lo_res  <= '0;
      MultOut <= 1'b0;
      DivOut  <= 1'b0;
      divZero <= 1'b0;
    end else begin
      MultOut <= 1'b0;
      DivOut  <= 1'b0;
      divZero <= 1'b0;
      case (state)
        IDLE: begin
          if (MultCtrl) begin
            mcand <= {A[WIDTH-1], A};
            mreg  <= {(WIDTH + 1)'(0), B, 1'b0};
            count <= '0;
            state <= MULT_RUN;
          end else if (DivCtrl) begin
            if (B == '0) begin
              divZero <= 1'b1;
              state   <= RELEASE;
            end else begin
              dvs    <= abs_b;
              quo    <= abs_a;
              rem    <= '0;
              sign_q <= A[WIDTH-1] ^ B[WIDTH-1];
              sign_r <= A[WIDTH-1];
              count  <= '0;
              state  <= DIV_RUN;
            end
          end
        end
        MULT_RUN: begin
          if (count == CNT_W'(WIDTH)) begin
            hi_res  <= mreg[2*WIDTH:WIDTH+1];
            lo_res  <= mreg[WIDTH:1];
            MultOut <= 1'b1;
            state   <= DONE;
          end else begin
            mreg  <= mult_step;
            count <= count + CNT_W'(1);
          end
        end
        DIV_RUN: begin
          if (count == CNT_W'(WIDTH)) begin
            state <= DIV_FIX;
          end else begin
            rem   <= rem_step;
            quo   <= quo_step;
            count <= count + CNT_W'(1);
          end
        end
        DIV_FIX: begin
          // Truncating division: quotient sign from operand signs, remainder follows dividend
          lo_res <= sign_q ? WIDTH'(0) - quo : quo;
          hi_res <= sign_r ? WIDTH'(0) - rem : rem;
          DivOut <= 1'b1;
          state  <= DONE;
        end
        DONE: state <= RELEASE;
        RELEASE: begin
          if (!MultCtrl && !DivCtrl) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MULTDIV_BUSY_EN
  // Mirrors the state entered at this edge: high in MULT_RUN, DIV_RUN, DIV_FIX, DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE:     busy <= MultCtrl || (DivCtrl && (B != '0));
        MULT_RUN: busy <= 1'b1;
        DIV_RUN:  busy <= 1'b1;
        DIV_FIX:  busy <= 1'b1;
        default:  busy <= 1'b0;
      endcase
    end
  end
`endif

endmodule
